// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and default constants for the sprite compositor.
//   enemy_cfg_t - one enemy layer's configuration {x, y, color, alive}
//   DEF_*       - default geometry and colour constants
//   idx_width() - width of an index into n entries (minimum 1)
// The enemy_cfg_t field widths are the compositor's default coordinate and
// colour widths; instances must keep COORD_W/COLOR_W at these values.
package sprite_pkg;

  localparam int DEF_COORD_W = 10;
  localparam int DEF_COLOR_W = 24;
  localparam int DEF_SPR_W   = 32;
  localparam int DEF_SPR_H   = 32;

  localparam logic [DEF_COLOR_W-1:0] DEF_BG_COLOR     = 24'hABFFFB;
  localparam logic [DEF_COLOR_W-1:0] DEF_PLAYER_COLOR = 24'h0000FF;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_COLOR_W-1:0] color;
    logic                   alive;
  } enemy_cfg_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: pixel stream, player position, enemy config port and
// composed outputs of the sprite compositor.
//   master: drives pixel_x/y, pixel_valid, frame_start, player_x/y, cfg_*;
//           receives rgb, rgb_valid, hit_mask, hit_valid
//   slave : the compositor side (mirror of master)
// Flow control: there is no valid/ready pair. pixel_valid qualifies the pixel
// each cycle, cfg_we qualifies a config write each cycle, and the compositor
// accepts every cycle unconditionally (no stall, no backpressure). rgb_valid
// and hit_valid are likewise one-cycle qualifiers with no acknowledge.
interface sprite_compositor_if
  import sprite_pkg::*;
#(
  parameter int N_ENEMIES = 3,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int IDX_W     = idx_width(N_ENEMIES)
);

  logic [COORD_W-1:0]   pixel_x;
  logic [COORD_W-1:0]   pixel_y;
  logic                 pixel_valid;
  logic                 frame_start;
  logic [COORD_W-1:0]   player_x;
  logic [COORD_W-1:0]   player_y;
  logic                 cfg_we;
  logic [IDX_W-1:0]     cfg_idx;
  logic [COORD_W-1:0]   cfg_x;
  logic [COORD_W-1:0]   cfg_y;
  logic [COLOR_W-1:0]   cfg_color;
  logic                 cfg_alive;
  logic [COLOR_W-1:0]   rgb;
  logic                 rgb_valid;
  logic [N_ENEMIES-1:0] hit_mask;
  logic                 hit_valid;

  modport master (
    output pixel_x, pixel_y, pixel_valid, frame_start, player_x, player_y,
           cfg_we, cfg_idx, cfg_x, cfg_y, cfg_color, cfg_alive,
    input  rgb, rgb_valid, hit_mask, hit_valid
  );

  modport slave (
    input  pixel_x, pixel_y, pixel_valid, frame_start, player_x, player_y,
           cfg_we, cfg_idx, cfg_x, cfg_y, cfg_color, cfg_alive,
    output rgb, rgb_valid, hit_mask, hit_valid
  );

endinterface

// File: rtl/sprite_hit.sv
// sprite_hit: combinational rectangle test for one sprite layer.
//   x, y   - sprite top-left corner
//   px, py - pixel under test
//   hit    - pixel lies inside the SPR_W x SPR_H box
// The far edge is computed one bit wider than the coordinates so sprites
// near the right/bottom border clip instead of wrapping to 0.
module sprite_hit #(
  parameter int COORD_W = 10,
  parameter int SPR_W   = 32,
  parameter int SPR_H   = 32
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  output logic               hit
);

  localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(SPR_H);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  assign x_end = {1'b0, x} + W_EXT;
  assign y_end = {1'b0, y} + H_EXT;

  assign hit = (px >= x) && ({1'b0, px} < x_end) &&
               (py >= y) && ({1'b0, py} < y_end);

endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: layered pixel compositor (background, player, enemies).
//   clk, rst - clock; asynchronous active-high reset
//   bus      - sprite_compositor_if.slave: pixel stream and player position in,
//              enemy config writes in, rgb/rgb_valid and hit_mask/hit_valid out
// Pipeline: stage 0 registers the pixel and commits shadow->active config on
// frame_start; stage 1 registers layer hits and the chosen colour; stage 2
// drives rgb and accumulates player/enemy collisions for the frame.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int                N_ENEMIES    = 3,
  parameter int                COORD_W      = DEF_COORD_W,
  parameter int                COLOR_W      = DEF_COLOR_W,
  parameter int                SPR_W        = DEF_SPR_W,
  parameter int                SPR_H        = DEF_SPR_H,
  parameter logic [COLOR_W-1:0] BG_COLOR     = DEF_BG_COLOR,
  parameter logic [COLOR_W-1:0] PLAYER_COLOR = DEF_PLAYER_COLOR
) (
  input logic                clk,
  input logic                rst,
  sprite_compositor_if.slave bus
);

  // ---------------- enemy config: shadow and active banks ----------------
  enemy_cfg_t shadow [N_ENEMIES];
  enemy_cfg_t active [N_ENEMIES];
  enemy_cfg_t wr_cfg;
  logic       cfg_ok;

  assign wr_cfg = '{x: bus.cfg_x, y: bus.cfg_y, color: bus.cfg_color,
                    alive: bus.cfg_alive};
  assign cfg_ok = bus.cfg_we && (int'(bus.cfg_idx) < N_ENEMIES);

  // The commit reads shadow before a same-cycle write lands, so a write
  // coinciding with frame_start only takes effect at the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ENEMIES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (bus.frame_start) begin
        for (int i = 0; i < N_ENEMIES; i++) active[i] <= shadow[i];
      end
      if (cfg_ok) shadow[bus.cfg_idx] <= wr_cfg;
    end
  end

  // ---------------- stage 0: pixel and player registers ----------------
  logic [COORD_W-1:0] s0_px, s0_py, s0_plx, s0_ply;
  logic               s0_valid, s0_fs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_px    <= '0;
      s0_py    <= '0;
      s0_plx   <= '0;
      s0_ply   <= '0;
      s0_valid <= 1'b0;
      s0_fs    <= 1'b0;
    end else begin
      s0_px    <= bus.pixel_x;
      s0_py    <= bus.pixel_y;
      s0_plx   <= bus.player_x;
      s0_ply   <= bus.player_y;
      s0_valid <= bus.pixel_valid;
      s0_fs    <= bus.frame_start;
    end
  end

  // ---------------- layer hit tests against the active set ----------------
  logic [N_ENEMIES-1:0] e_rect, e_alive, e_hit;
  logic                 p_hit;

  for (genvar i = 0; i < N_ENEMIES; i++) begin : g_enemy
    sprite_hit #(.COORD_W(COORD_W), .SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .x  (active[i].x),
      .y  (active[i].y),
      .px (s0_px),
      .py (s0_py),
      .hit(e_rect[i])
    );
    assign e_alive[i] = active[i].alive;
  end

  sprite_hit #(.COORD_W(COORD_W), .SPR_W(SPR_W), .SPR_H(SPR_H)) u_player_hit (
    .x  (s0_plx),
    .y  (s0_ply),
    .px (s0_px),
    .py (s0_py),
    .hit(p_hit)
  );

  assign e_hit = e_rect & e_alive;

  // Priority mux: ascending loop so the highest-index enemy wins, then the
  // player, then background. The colour is resolved here and carried down
  // the pipe so a later commit cannot recolour an in-flight pixel.
  logic [COLOR_W-1:0] pix_color;

  always_comb begin
    pix_color = BG_COLOR;
    if (p_hit) pix_color = PLAYER_COLOR;
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (e_hit[i]) pix_color = active[i].color;
    end
  end

  // ---------------- stage 1: hits, colour, tags ----------------
  logic [N_ENEMIES-1:0] s1_ehit;
  logic                 s1_phit, s1_valid, s1_fs;
  logic [COLOR_W-1:0]   s1_color;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ehit  <= '0;
      s1_phit  <= 1'b0;
      s1_valid <= 1'b0;
      s1_fs    <= 1'b0;
      s1_color <= '0;
    end else begin
      s1_ehit  <= e_hit;
      s1_phit  <= p_hit;
      s1_valid <= s0_valid;
      s1_fs    <= s0_fs;
      s1_color <= pix_color;
    end
  end

  // ---------------- stage 2: output and collision accumulation ----------------
  logic [N_ENEMIES-1:0] overlap, acc, hit_mask_q;
  logic [COLOR_W-1:0]   rgb_q;
  logic                 rgb_valid_q, hit_valid_q;

  assign overlap = s1_valid ? (s1_ehit & {N_ENEMIES{s1_phit}}) : '0;

  // A frame_start pixel reports the finished frame and seeds the new one
  // with its own overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
      hit_mask_q  <= '0;
      hit_valid_q <= 1'b0;
      acc         <= '0;
    end else begin
      rgb_q       <= s1_valid ? s1_color : '0;
      rgb_valid_q <= s1_valid;
      hit_valid_q <= s1_fs;
      if (s1_fs) begin
        hit_mask_q <= acc;
        acc        <= overlap;
      end else begin
        acc <= acc | overlap;
      end
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.rgb_valid = rgb_valid_q;
  assign bus.hit_mask  = hit_mask_q;
  assign bus.hit_valid = hit_valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed bench for sprite_compositor with a
// behavioural reference model and an expected-output queue.
module tb_sprite_compositor;

  localparam int N  = 3;
  localparam int EW = 1 + N + 1 + 24;   // {hit_valid, hit_mask, rgb_valid, rgb}
  localparam logic [23:0] BG  = 24'hABFFFB;
  localparam logic [23:0] PLC = 24'h0000FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_compositor_if #(.N_ENEMIES(N), .COORD_W(10), .COLOR_W(24)) bus ();

  sprite_compositor #(.N_ENEMIES(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state
  int          sx [N], sy [N], ax [N], ay [N];
  logic [23:0] sc [N], ac [N];
  bit          sa [N], aa [N];
  logic [N-1:0] m_acc, m_mask;
  int pl_x = 600;
  int pl_y = 600;

  function automatic bit in_rect(input int px, py, x, y);
    return (px >= x) && (px < x + 32) && (py >= y) && (py < y + 32);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sx[i] = 0; sy[i] = 0; sc[i] = '0; sa[i] = 0;
      ax[i] = 0; ay[i] = 0; ac[i] = '0; aa[i] = 0;
    end
    m_acc  = '0;
    m_mask = '0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    bus.pixel_x = '0; bus.pixel_y = '0; bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_idx = '0;
    bus.cfg_x = '0; bus.cfg_y = '0; bus.cfg_color = '0; bus.cfg_alive = 1'b0;
    bus.player_x = 10'(pl_x); bus.player_y = 10'(pl_y);
  endtask

  // One cycle of stimulus; the model computes the output this pixel yields.
  task automatic step(input int px, input int py, input bit v, input bit fs,
                      input bit we = 0, input int idx = 0, input int cx = 0,
                      input int cy = 0, input logic [23:0] cc = '0,
                      input bit ca = 0);
    logic [N-1:0] eh, ov;
    bit           ph, hv;
    logic [23:0]  col;
    @(posedge clk);
    #1;
    bus.pixel_x = 10'(px); bus.pixel_y = 10'(py);
    bus.pixel_valid = v; bus.frame_start = fs;
    bus.player_x = 10'(pl_x); bus.player_y = 10'(pl_y);
    bus.cfg_we = we; bus.cfg_idx = 2'(idx);
    bus.cfg_x = 10'(cx); bus.cfg_y = 10'(cy);
    bus.cfg_color = cc; bus.cfg_alive = ca;
    if (fs) begin
      for (int i = 0; i < N; i++) begin
        ax[i] = sx[i]; ay[i] = sy[i]; ac[i] = sc[i]; aa[i] = sa[i];
      end
    end
    if (we && idx < N) begin
      sx[idx] = cx; sy[idx] = cy; sc[idx] = cc; sa[idx] = ca;
    end
    ph  = in_rect(px, py, pl_x, pl_y);
    col = ph ? PLC : BG;
    for (int i = 0; i < N; i++) begin
      eh[i] = aa[i] && in_rect(px, py, ax[i], ay[i]);
      if (eh[i]) col = ac[i];
    end
    if (!v) col = '0;
    ov = v ? (eh & {N{ph}}) : '0;
    if (fs) begin
      m_mask = m_acc;
      m_acc  = ov;
      hv     = 1'b1;
    end else begin
      m_acc = m_acc | ov;
      hv    = 1'b0;
    end
    exp_q.push_back({hv, m_mask, v, col});
  endtask

  task automatic check_now(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
    vectors++;
    assert (got === want)
    else begin
      miscompares++;
      $error("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  // Scoreboard: an input driven after edge P is seen at the output after
  // edge P+3, so three entries are always in flight.
  always @(negedge clk) begin
    logic [EW-1:0] e, got;
    if (!rst) begin
      while (exp_q.size() > 3) begin
        e   = exp_q.pop_front();
        got = {bus.hit_valid, bus.hit_mask, bus.rgb_valid, bus.rgb};
        vectors++;
        assert (got === e)
        else begin
          miscompares++;
          $error("FAIL pixel_out got hv=%b mask=%b rv=%b rgb=%h expected hv=%b mask=%b rv=%b rgb=%h",
                 got[EW-1], got[EW-2 -: N], got[24], got[23:0],
                 e[EW-1], e[EW-2 -: N], e[24], e[23:0]);
        end
      end
    end
  end

  initial begin
    model_reset();
    idle_inputs();
    #12;
    check_now("reset_rgb",       32'(bus.rgb),       32'h0);
    check_now("reset_rgb_valid", 32'(bus.rgb_valid), 32'h0);
    check_now("reset_hit_mask",  32'(bus.hit_mask),  32'h0);
    check_now("reset_hit_valid", 32'(bus.hit_valid), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Background with nothing alive
    step(0, 0, 1, 0);
    // Enemy 1 red at (100,100), committed by frame_start
    step(0, 0, 0, 0, 1, 1, 100, 100, 24'hFF0000, 1);
    step(0, 0, 1, 1);
    step(131, 131, 1, 0);
    step(132, 100, 1, 0);
    step(100, 100, 1, 0);
    step(99, 131, 1, 0);
    // Write without frame_start stays in shadow
    step(0, 0, 0, 0, 1, 0, 132, 100, 24'h00FF00, 1);
    step(132, 100, 1, 0);
    // Write coinciding with frame_start lands in shadow only
    step(131, 131, 1, 1, 1, 1, 100, 100, 24'hFF0000, 0);
    step(132, 100, 1, 0);
    step(0, 0, 1, 1);
    step(131, 131, 1, 0);

    // Player and stacked enemies
    pl_x = 100; pl_y = 100;
    step(0, 0, 0, 0, 1, 0, 110, 110, 24'h00FF00, 1);
    step(0, 0, 0, 0, 1, 2, 110, 110, 24'h123456, 1);
    step(0, 0, 1, 1);
    step(115, 115, 1, 0);
    step(105, 105, 1, 0);
    step(115, 115, 0, 0);
    // Frame k: only enemy 2 alive and overlapping the player
    step(0, 0, 0, 0, 1, 0, 110, 110, 24'h00FF00, 0);
    step(0, 0, 1, 1);
    step(115, 115, 1, 0);
    step(116, 120, 1, 0);
    step(0, 0, 1, 1);     // reports enemy-2 overlap
    step(300, 300, 1, 0);
    step(0, 0, 1, 1);     // quiet frame reports zero
    // Back-to-back frame_start pulses
    step(0, 0, 1, 1);
    step(115, 115, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);

    // Right-edge clipping and out-of-range index
    pl_x = 600; pl_y = 600;
    step(0, 0, 0, 0, 1, 0, 1020, 0, 24'h0000AA, 1);
    step(0, 0, 0, 0, 1, 3, 0, 0, 24'hEEEEEE, 1);
    step(0, 0, 1, 1);
    step(0, 5, 1, 0);
    step(1023, 5, 1, 0);
    step(1019, 5, 1, 0);
    step(5, 5, 1, 0);

    // Randomised pixels around the sprites with occasional frame starts
    pl_x = 100; pl_y = 100;
    step(0, 0, 0, 0, 1, 1, 120, 95, 24'hC0FFEE, 1);
    for (int k = 0; k < 40; k++) begin
      step(int'($urandom_range(90, 150)), int'($urandom_range(90, 150)),
           bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) == 0));
    end

    // Mid-frame reset with a nonzero hit_mask and a valid pixel in flight
    step(0, 0, 1, 1);
    step(115, 115, 1, 0);
    step(0, 0, 1, 1);
    step(115, 115, 1, 0);
    step(10, 10, 1, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_now("midrst_rgb",       32'(bus.rgb),       32'h0);
    check_now("midrst_rgb_valid", 32'(bus.rgb_valid), 32'h0);
    check_now("midrst_hit_mask",  32'(bus.hit_mask),  32'h0);
    check_now("midrst_hit_valid", 32'(bus.hit_valid), 32'h0);
    model_reset();
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // After release: no hit_valid until the next frame_start
    step(115, 115, 1, 0);
    step(0, 0, 0, 0, 1, 2, 110, 110, 24'h123456, 1);
    step(115, 115, 1, 0);
    step(200, 200, 1, 0);
    step(0, 0, 1, 1);
    step(115, 115, 1, 0);
    step(0, 0, 1, 1);

    repeat (4) step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised layered pixel compositor for the VGA painter path. Each display pixel is composed from a background colour, one player sprite and N_ENEMIES enemy sprites; enemy positions, colours and alive flags are held in double-buffered config registers committed at frame start. Output is a 2-cycle pipelined RGB stream plus a per-frame player/enemy collision mask. Sits between the VGA timing counter and the DAC/output register.

## Interface
- N_ENEMIES, 3: number of enemy layers (1..16)
- COORD_W, 10: pixel coordinate width
- COLOR_W, 24: RGB width
- SPR_W, 32: sprite width in pixels, all layers
- SPR_H, 32: sprite height in pixels, all layers
- BG_COLOR, 24'hABFFFB: background colour
- PLAYER_COLOR, 24'h0000FF: player sprite colour
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- pixel_x, pixel_y  in  COORD_W each  current pixel coordinate
- pixel_valid  in  1  pixel is in the visible area
- frame_start  in  1  one-cycle pulse on the first pixel of a frame
- player_x, player_y  in  COORD_W each  player top-left corner, sampled every cycle
- cfg_we  in  1  enemy config write strobe
- cfg_idx  in  $clog2(N_ENEMIES) (min 1)  enemy index
- cfg_x, cfg_y  in  COORD_W each  enemy top-left corner
- cfg_color  in  COLOR_W  enemy colour
- cfg_alive  in  1  enemy drawn and collidable
- rgb  out  COLOR_W  composed colour
- rgb_valid  out  1  rgb corresponds to a valid pixel
- hit_mask  out  N_ENEMIES  enemies that overlapped the player during the previous frame
- hit_valid  out  1  one-cycle pulse; hit_mask just updated

## Operation
- Config: a cfg_we write loads {x,y,color,alive} into shadow[cfg_idx]. If cfg_idx >= N_ENEMIES, the write is ignored. On a frame_start edge, active <= shadow for all enemies. A write in the same cycle as frame_start lands in shadow only and commits at the next frame_start.
- Hit test per layer: hit = (px >= x) && (px < x+SPR_W) && (py >= y) && (py < y+SPR_H). Sums use COORD_W+1 bits, so sprites near the right or bottom edge do not wrap. Enemy hit also requires active alive=1.
- Priority, top to bottom: enemy N_ENEMIES-1 … enemy 0, then player, then BG_COLOR.
- Invalid pixel: rgb=0, rgb_valid=0, no collision accumulation.
- Collision: on each valid pixel where the player hit and enemy i hit are both true, set acc[i] (sticky).
- When a frame_start-tagged pixel reaches the output stage:
  - hit_mask <= acc, without that pixel's overlap.
  - hit_valid pulses.
  - acc <= that pixel's overlap bits, or 0 if the pixel is invalid.
- Reset clears shadow, active, acc, the pipeline, and all outputs, which go to 0.

## Timing
- Stage 0 (edge T): register pixel_x/y, pixel_valid, frame_start, player_x/y. Commit shadow->active if frame_start.
- Stage 1 (edge T+1): register per-layer hit vector, player hit, valid and frame_start tags. Hit tests use the post-commit active set, so the frame_start pixel already sees the new config.
- Stage 2 (edge T+2): rgb, rgb_valid, collision accumulate, hit_mask/hit_valid.
- Latency: 2 cycles from input sample to output. Throughput: 1 pixel/cycle. No stall or backpressure.
- Back-to-back frame_start pulses are legal. Each one produces hit_valid and may produce an all-zero hit_mask.
- Reset asserted mid-frame:
  - Outputs clear asynchronously.
  - After release, the first hit_valid is produced only by the next frame_start.
  - rgb_valid reflects inputs 2 cycles after release.

## Structure
- Shared package sprite_pkg:
  - typedef enemy_cfg_t {x, y, color, alive}
  - default colour constants
  - SPR_W/SPR_H defaults
- Sub-module sprite_hit: one combinational rectangle test (x, y, px, py -> hit), instantiated N_ENEMIES+1 times via generate.
- Compositor priority mux: a for-loop in the top module, not a chain of instances.

## Test plan
- Reset, then pixel_valid=1 at (0,0) with no enemies alive -> rgb=24'hABFFFB, rgb_valid=1 two cycles later.
- Write enemy 1 = (100,100,24'hFF0000,alive), then frame_start:
  - Pixel (131,131) -> red.
  - Pixel (132,100) -> BG_COLOR.
  - Write without frame_start -> still BG_COLOR.
- Player at (100,100); enemies 0 and 2 both alive at (110,110) with colours 24'h00FF00 and 24'h123456 -> pixel (115,115) gives 24'h123456; pixel (105,105) gives PLAYER_COLOR.
- Overlap of player and enemy 2 during frame k -> at frame k+1 frame_start, hit_valid pulses with hit_mask=3'b100. Frame k+1 has no overlap -> next hit_mask=3'b000.
- Enemy at x=1020 with SPR_W=32 -> pixel (0,y) not hit (no wrap). cfg_idx=3 with N_ENEMIES=3 is ignored.
- Assert rst mid-frame with rgb_valid=1 -> rgb=0, rgb_valid=0, hit_mask=0 immediately. No hit_valid until the next frame_start.
